// File: rtl/axi4_lite_pkg.sv
// Shared types and default widths for the single-outstanding AXI4-Lite initiator.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP
  } mst_state_t;

  localparam int unsigned DEF_ADDR_W         = 32;
  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: cmd port in, one AXI transaction, rsp port out.
// Define AXI_MST_TIMEOUT_EN to add a watchdog that ends a stalled transaction with DECERR and timeout_o.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,   // 32 or 64
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int unsigned STRB_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
`ifdef AXI_MST_TIMEOUT_EN
  output logic              timeout_o,
`endif
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp
);

  mst_state_t        state_q, state_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  resp_t             rsp_resp_q, rsp_resp_d;
`ifdef AXI_MST_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef AXI_MST_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            araddr_d  = cmd_addr;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; the response phase opens once both are gone.
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = resp_t'(bresp);
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = rdata;
          rsp_resp_d  = resp_t'(rresp);
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
`ifdef AXI_MST_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AXI_MST_TIMEOUT_EN
    // Watchdog overrides whatever the channel logic decided on the expiring cycle.
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q != RSP) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_write_d = (state_q == WR_REQ) || (state_q == WR_RESP);
        rsp_rdata_d = '0;
        rsp_resp_d  = DECERR;
        timeout_d   = 1'b1;
        state_d     = RSP;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
`ifdef AXI_MST_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
`ifdef AXI_MST_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign awvalid   = awvalid_q;
  assign awaddr    = awaddr_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
`ifdef AXI_MST_TIMEOUT_EN
  assign timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: behavioural AXI4-Lite slave with tunable delays, memory model, directed + random steps.
`timescale 1ns/1ps
module tb_axi4_lite_master;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
`ifdef AXI_MST_TIMEOUT_EN
  logic        timeout_o;
`endif

  always #5 clk = ~clk;

  axi4_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
`ifdef AXI_MST_TIMEOUT_EN
    .timeout_o(timeout_o),
`endif
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];

  int   aw_dly, ar_dly, w_dly, b_dly, r_dly;
  logic w_always, never_ar;
  logic [1:0] bresp_cfg, rresp_cfg;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    model_mem[a] = (model_read(a) & ~mask) | (d & mask);
  endtask

  // Behavioural slave: each ready rises <dly> cycles after its valid is seen, responses after both beats.
  logic        wready_r, got_aw, got_w, got_ar;
  logic [31:0] aw_lat, ar_lat, wd_lat;
  logic [3:0]  ws_lat;
  int          aw_c, w_c, ar_c, b_c, r_c;
  assign wready = w_always ? 1'b1 : wready_r;

  always @(posedge clk or posedge reset) begin : slave
    logic aw_now, w_now, ar_now;
    logic [31:0] a_now, d_now, r_addr, merged;
    logic [3:0]  s_now;
    if (reset) begin
      awready <= 1'b0; wready_r <= 1'b0; arready <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= 32'h0; rresp <= 2'b00;
      got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0;
      aw_lat <= 32'h0; ar_lat <= 32'h0; wd_lat <= 32'h0; ws_lat <= 4'h0;
      aw_c <= 0; w_c <= 0; ar_c <= 0; b_c <= 0; r_c <= 0;
    end else begin
      if (awvalid && awready) begin
        awready <= 1'b0; aw_c <= 0; got_aw <= 1'b1; aw_lat <= awaddr;
        if (exp_q.size() == 0) check("aw_unexpected", 64'(1), 64'(0));
        else check("awaddr", 64'(awaddr), 64'(exp_q.pop_front()));
      end else if (awvalid) begin
        if (aw_c >= aw_dly) awready <= 1'b1; else aw_c <= aw_c + 1;
      end else aw_c <= 0;

      if (wvalid && wready) begin
        wready_r <= 1'b0; w_c <= 0; got_w <= 1'b1; wd_lat <= wdata; ws_lat <= wstrb;
      end else if (wvalid && !w_always) begin
        if (w_c >= w_dly) wready_r <= 1'b1; else w_c <= w_c + 1;
      end else w_c <= 0;

      aw_now = got_aw || (awvalid && awready);
      w_now  = got_w || (wvalid && wready);
      a_now  = (awvalid && awready) ? awaddr : aw_lat;
      d_now  = (wvalid && wready) ? wdata : wd_lat;
      s_now  = (wvalid && wready) ? wstrb : ws_lat;
      if (aw_now && w_now && !bvalid) begin
        if (b_c >= b_dly) begin
          bvalid <= 1'b1; bresp <= bresp_cfg;
          merged = slave_mem.exists(a_now) ? slave_mem[a_now] : 32'h0;
          for (int i = 0; i < 4; i++) if (s_now[i]) merged[8*i +: 8] = d_now[8*i +: 8];
          slave_mem[a_now] = merged;
        end else b_c <= b_c + 1;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0; b_c <= 0;
      end

      if (arvalid && arready) begin
        arready <= 1'b0; ar_c <= 0; got_ar <= 1'b1; ar_lat <= araddr;
        if (exp_q.size() == 0) check("ar_unexpected", 64'(1), 64'(0));
        else check("araddr", 64'(araddr), 64'(exp_q.pop_front()));
      end else if (arvalid && !never_ar) begin
        if (ar_c >= ar_dly) arready <= 1'b1; else ar_c <= ar_c + 1;
      end else ar_c <= 0;

      ar_now = got_ar || (arvalid && arready);
      r_addr = (arvalid && arready) ? araddr : ar_lat;
      if (ar_now && !rvalid) begin
        if (r_c >= r_dly) begin
          rvalid <= 1'b1; rresp <= rresp_cfg;
          rdata  <= slave_mem.exists(r_addr) ? slave_mem[r_addr] : 32'h0;
        end else r_c <= r_c + 1;
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0; got_ar <= 1'b0; r_c <= 0;
      end
    end
  end

  // Protocol monitor on the falling edge: valid/payload hold, AW+W together, bready only after both beats.
  logic        p_ok, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  int          w_only = 0;
  always @(negedge clk) begin
    if (reset) begin
      p_ok <= 1'b0;
    end else begin
      if (p_ok) begin
        if (p_awv && !p_awr) begin
          check("awvalid_hold", 64'(awvalid), 64'(1));
          check("awaddr_stable", 64'(awaddr), 64'(p_awaddr));
        end
        if (p_wv && !p_wr) begin
          check("wvalid_hold", 64'(wvalid), 64'(1));
          check("wdata_stable", 64'(wdata), 64'(p_wdata));
        end
        if (p_arv && !p_arr) begin
          check("arvalid_hold", 64'(arvalid), 64'(1));
          check("araddr_stable", 64'(araddr), 64'(p_araddr));
        end
        if (!p_awv && awvalid) check("aw_w_together", 64'(wvalid), 64'(1));
      end
      if (bready) check("bready_after_both", 64'(awvalid | wvalid), 64'(0));
      if (awvalid && !wvalid) w_only <= w_only + 1;
      p_ok <= 1'b1;
      p_awv <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
      p_wv  <= wvalid;  p_wr  <= wready;  p_wdata  <= wdata;
      p_arv <= arvalid; p_arr <= arready; p_araddr <= araddr;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valids"}, 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_write}), 64'(0));
    check({tag, "_awaddr"}, 64'(awaddr), 64'(0));
    check({tag, "_araddr"}, 64'(araddr), 64'(0));
    check({tag, "_wdata_wstrb"}, 64'({wdata, wstrb}), 64'(0));
    check({tag, "_rsp_payload"}, 64'({rsp_rdata, rsp_resp}), 64'(0));
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
  endtask

  // Issues one command, waits for its response, holds rsp_ready low <hold> cycles, then consumes it.
  // lat counts clock edges from the accepting edge to the edge that raised rsp_valid.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int hold, input logic expect_bus,
                         output int lat, output logic [31:0] r_data, output logic [1:0] r_resp,
                         output logic r_write, output logic r_tmo);
    int t;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    if (expect_bus) exp_q.push_back(addr);
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    check("cmd_accept_bound", 64'(t < 50), 64'(1));
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom_range(0, 15));
    lat = 0;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    check("rsp_wait_bound", 64'(lat < 200), 64'(1));
    r_data = rsp_rdata; r_resp = rsp_resp; r_write = rsp_write;
`ifdef AXI_MST_TIMEOUT_EN
    r_tmo = timeout_o;
`else
    r_tmo = 1'b0;
`endif
    check("cmd_ready_in_rsp", 64'(cmd_ready), 64'(0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_hold_valid", 64'(rsp_valid), 64'(1));
      check("rsp_hold_payload", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'({r_write, r_resp, r_data}));
      check("cmd_ready_busy", 64'(cmd_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_dropped", 64'(rsp_valid), 64'(0));
    check("idle_after_rsp", 64'(cmd_ready), 64'(1));
  endtask

  task automatic zero_wait_slave();
    aw_dly = 0; ar_dly = 0; w_dly = 0; b_dly = 0; r_dly = 0;
    w_always = 1'b0; never_ar = 1'b0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;
  endtask

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          lat, t, wo0;
    logic [31:0] rd, a, d;
    logic [1:0]  rs;
    logic        rw, rt, wr;
    logic [3:0]  s;

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0;
    zero_wait_slave();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    reset = 1'b0;

    // Zero-wait write then read-back
    run_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b1, lat, rd, rs, rw, rt);
    model_write(32'h10, 32'hDEAD_BEEF, 4'hF);
    check("wr_latency", 64'(lat), 64'(3));
    check("wr_resp", 64'({rw, rs, rd}), 64'({1'b1, 2'b00, 32'h0}));
    run_cmd(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b1, lat, rd, rs, rw, rt);
    check("rd_latency", 64'(lat), 64'(3));
    check("rd_data", 64'(rd), 64'(model_read(32'h10)));
    check("rd_resp", 64'({rw, rs}), 64'({1'b0, 2'b00}));

    // AW stalled, W accepted at once: W retires alone, AW held, response after AW completes
    aw_dly = 4; w_always = 1'b1;
    wo0 = w_only;
    run_cmd(1'b1, 32'h20, 32'h1234_5678, 4'b0101, 0, 1'b1, lat, rd, rs, rw, rt);
    model_write(32'h20, 32'h1234_5678, 4'b0101);
    check("aw_stall_w_only_cycles", 64'(w_only - wo0), 64'(aw_dly + 1));
    check("aw_stall_latency", 64'(lat), 64'(aw_dly + 3));
    check("aw_stall_resp", 64'({rw, rs}), 64'({1'b1, 2'b00}));
    zero_wait_slave();
    run_cmd(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b1, lat, rd, rs, rw, rt);
    check("partial_strobe_rd", 64'(rd), 64'(model_read(32'h20)));

    // Slow SLVERR read with back-pressured response
    rresp_cfg = 2'b10; r_dly = 5;
    run_cmd(1'b0, 32'h10, 32'h0, 4'h0, 3, 1'b1, lat, rd, rs, rw, rt);
    check("slverr_resp", 64'(rs), 64'(2'b10));
    check("slverr_data", 64'(rd), 64'(model_read(32'h10)));
    check("slverr_latency", 64'(lat), 64'(r_dly + 3));
    zero_wait_slave();

    // Reset while waiting for B: outputs clear without a clock edge, no response follows
    b_dly = 20;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'hCAFE_F00D; cmd_wstrb = 4'hF;
    exp_q.push_back(32'h30);
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (!bready && t < 50) begin @(negedge clk); t++; end
    check("reach_wr_resp_bound", 64'(t < 50), 64'(1));
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    zero_wait_slave();
    check("aborted_exp_q_empty", 64'(exp_q.size()), 64'(0));
    repeat (3) begin
      @(negedge clk);
      check("no_rsp_after_abort", 64'(rsp_valid), 64'(0));
    end
    run_cmd(1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b1, lat, rd, rs, rw, rt);
    check("aborted_write_not_stored", 64'(rd), 64'(model_read(32'h30)));
    run_cmd(1'b1, 32'h30, 32'h0BAD_F00D, 4'hF, 0, 1'b1, lat, rd, rs, rw, rt);
    model_write(32'h30, 32'h0BAD_F00D, 4'hF);
    check("post_reset_wr_latency", 64'(lat), 64'(3));
    run_cmd(1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b1, lat, rd, rs, rw, rt);
    check("post_reset_rd", 64'(rd), 64'(model_read(32'h30)));

    // Randomised traffic against the memory model
    for (int k = 0; k < 40; k++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      w_always = 1'($urandom_range(0, 1));
      bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      a  = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      run_cmd(wr, a, d, s, $urandom_range(0, 2), 1'b1, lat, rd, rs, rw, rt);
      if (wr) begin
        model_write(a, d, s);
        check("rnd_wr_rsp", 64'({rw, rs, rd}), 64'({1'b1, bresp_cfg, 32'h0}));
      end else begin
        check("rnd_rd_rsp", 64'({rw, rs}), 64'({1'b0, rresp_cfg}));
        check("rnd_rd_data", 64'(rd), 64'(model_read(a)));
      end
    end
    zero_wait_slave();

`ifdef AXI_MST_TIMEOUT_EN
    // Slave never accepts AR: watchdog answers with DECERR after TO cycles
    never_ar = 1'b1;
    run_cmd(1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0, lat, rd, rs, rw, rt);
    check("timeout_latency", 64'(lat), 64'(TO));
    check("timeout_resp", 64'({rs, rd}), 64'({2'b11, 32'h0}));
    check("timeout_flag", 64'(rt), 64'(1));
    check("timeout_arvalid_dropped", 64'(arvalid), 64'(0));
    zero_wait_slave();
`endif

    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
